// File: rtl/fib_host.sv
// Requester/checker for the fib accelerator: issues a run of consecutive indices,
// one outstanding request at a time, and checks each result against a golden Fibonacci value.
module fib_host #(
  parameter int IDX_W   = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W-1:0]  first_idx,
  input  logic [IDX_W-1:0]  num_req,
  output logic              busy,
  output logic              done,
  output logic [7:0]        err_cnt,
  output logic              timeout,
  output logic [DATA_W-1:0] last_result,
  output logic [IDX_W-1:0]  req_idx,
  output logic              req_vld,
  input  logic              req_rdy,
  input  logic [DATA_W-1:0] rsp_data,
  input  logic              rsp_vld,
  output logic              rsp_rdy
);

  localparam int                CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [IDX_W-1:0]  IDX_MAX = {IDX_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_SEND  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_cur_idx, w_cur_idx_nxt;
  logic [IDX_W-1:0]    r_remaining, w_remaining_nxt;
  logic [IDX_W-1:0]    r_k, w_k_nxt;
  logic [DATA_W-1:0]   r_a, w_a_nxt;
  logic [DATA_W-1:0]   r_b, w_b_nxt;
  logic [CNT_W-1:0]    r_wait_cnt, w_wait_cnt_nxt;
  logic [7:0]          r_err_cnt, w_err_cnt_nxt;
  logic                r_timeout, w_timeout_nxt;
  logic [DATA_W-1:0]   r_last_result, w_last_result_nxt;
  logic                r_busy, r_done, r_req_vld, r_rsp_rdy;

  logic [DATA_W-1:0]   w_fib_sum;
  logic [CNT_W-1:0]    w_wait_inc;
  logic [7:0]          w_err_inc;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_fib_sum  = r_a + r_b;
  assign w_wait_inc = r_wait_cnt + CNT_W'(1);
  assign w_err_inc  = sat_inc8(r_err_cnt);

  // Next-state and datapath updates for the run sequencer
  always_comb begin
    w_state_nxt       = r_state;
    w_cur_idx_nxt     = r_cur_idx;
    w_remaining_nxt   = r_remaining;
    w_k_nxt           = r_k;
    w_a_nxt           = r_a;
    w_b_nxt           = r_b;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_err_cnt_nxt     = r_err_cnt;
    w_timeout_nxt     = r_timeout;
    w_last_result_nxt = r_last_result;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_cur_idx_nxt   = first_idx;
          w_remaining_nxt = num_req;
          w_err_cnt_nxt   = 8'd0;
          w_timeout_nxt   = 1'b0;
          w_a_nxt         = {DATA_W{1'b0}};
          w_b_nxt         = DATA_W'(1);
          w_k_nxt         = {IDX_W{1'b0}};
          w_state_nxt     = (num_req == {IDX_W{1'b0}}) ? S_DONE : S_PRIME;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PRIME: begin
        if (r_k != r_cur_idx) begin
          w_a_nxt = r_b;
          w_b_nxt = w_fib_sum;
          w_k_nxt = r_k + IDX_W'(1);
        end else begin
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (req_rdy) begin
          w_wait_cnt_nxt = {CNT_W{1'b0}};
          w_state_nxt    = S_WAIT;
        end else begin
          w_state_nxt = S_SEND;
        end
      end
      S_WAIT: begin
        if (rsp_vld) begin
          w_last_result_nxt = rsp_data;
          w_err_cnt_nxt     = (rsp_data != r_a) ? w_err_inc : r_err_cnt;
          // Index wrap restarts the golden sequence at fib(0)
          if (r_cur_idx == IDX_MAX) begin
            w_a_nxt = {DATA_W{1'b0}};
            w_b_nxt = DATA_W'(1);
          end else begin
            w_a_nxt = r_b;
            w_b_nxt = w_fib_sum;
          end
          w_cur_idx_nxt   = r_cur_idx + IDX_W'(1);
          w_remaining_nxt = r_remaining - IDX_W'(1);
          w_state_nxt     = (r_remaining == IDX_W'(1)) ? S_DONE : S_SEND;
        end else if (w_wait_inc == TO_VAL) begin
          w_timeout_nxt = 1'b1;
          w_err_cnt_nxt = w_err_inc;
          w_state_nxt   = S_DONE;
        end else begin
          w_wait_cnt_nxt = w_wait_inc;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake/status outputs
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cur_idx     <= {IDX_W{1'b0}};
      r_remaining   <= {IDX_W{1'b0}};
      r_k           <= {IDX_W{1'b0}};
      r_a           <= {DATA_W{1'b0}};
      r_b           <= DATA_W'(1);
      r_wait_cnt    <= {CNT_W{1'b0}};
      r_err_cnt     <= 8'd0;
      r_timeout     <= 1'b0;
      r_last_result <= {DATA_W{1'b0}};
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_req_vld     <= 1'b0;
      r_rsp_rdy     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cur_idx     <= w_cur_idx_nxt;
      r_remaining   <= w_remaining_nxt;
      r_k           <= w_k_nxt;
      r_a           <= w_a_nxt;
      r_b           <= w_b_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_err_cnt     <= w_err_cnt_nxt;
      r_timeout     <= w_timeout_nxt;
      r_last_result <= w_last_result_nxt;
      r_busy        <= (w_state_nxt != S_IDLE);
      r_done        <= (w_state_nxt == S_DONE);
      r_req_vld     <= (w_state_nxt == S_SEND);
      r_rsp_rdy     <= (w_state_nxt == S_WAIT);
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign err_cnt     = r_err_cnt;
  assign timeout     = r_timeout;
  assign last_result = r_last_result;
  assign req_idx     = r_cur_idx;
  assign req_vld     = r_req_vld;
  assign rsp_rdy     = r_rsp_rdy;

endmodule

// File: doc/fib_host.md
Name: fib_host

Overview:
- Requester/checker on the far end of the fib accelerator's valid/ready interface.
- On a start command, issues a run of consecutive Fibonacci indices to the accelerator, one outstanding request at a time.
- Collects each 32-bit result and compares it against an internally computed golden value (mod 2^32), counting mismatches and timeouts.
- Used as on-chip self-test and as the bench-side driver for the accelerator.

Parameters:
IDX_W, 8, index width; matches the accelerator index input.
DATA_W, 32, result width; golden arithmetic is mod 2^DATA_W.
TIMEOUT, 255, max cycles waiting for a response before abort; must be >= 1.

Ports:
CLK  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  command pulse; sampled only in IDLE.
first_idx  in  IDX_W  first index of run; sampled with start.
num_req  in  IDX_W  number of requests in run; sampled with start.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse at end of run.
err_cnt  out  8  mismatch+timeout count for current run; saturates at 255.
timeout  out  1  sticky; set on response timeout, cleared by next accepted start.
last_result  out  DATA_W  most recent response data.
req_idx  out  IDX_W  index to accelerator.
req_vld  out  1  request valid.
req_rdy  in  1  accelerator ready to accept.
rsp_data  in  DATA_W  result from accelerator.
rsp_vld  in  1  result valid.
rsp_rdy  out  1  host ready for result.

Behaviour:
- Clock/reset: one clock CLK; reset rst_n is asynchronous, active-low.
- Reset (async assert, any state): state=IDLE. All outputs 0: busy, done, err_cnt, timeout, last_result, req_idx, req_vld, rsp_rdy. Internal golden a=0, b=1, counters=0.
- Golden sequence: a=fib(k), b=fib(k+1), with fib(0)=0, fib(1)=1. Advance is a<=b, b<=a+b, truncated to DATA_W.
- IDLE:
  - start=1 latches first_idx to cur_idx and num_req to remaining.
  - Same edge clears err_cnt and timeout, sets a=0, b=1, k=0.
  - Go to DONE if num_req==0, else PRIME.
  - start outside IDLE is ignored.
- PRIME:
  - While k!=cur_idx: advance golden, k++ (one step per cycle).
  - When k==cur_idx, go to SEND. PRIME therefore lasts first_idx+1 cycles (first_idx=0 gives 1 cycle).
- SEND:
  - req_vld=1, req_idx=cur_idx.
  - Both held stable until the req_vld&&req_rdy handshake, then go to WAIT.
  - rsp_rdy=0.
- WAIT:
  - rsp_rdy=1, req_vld=0, wait counter increments each cycle.
  - On rsp_vld (rsp_vld&&rsp_rdy):
    - last_result<=rsp_data.
    - If rsp_data!=a, err_cnt++ (saturating).
    - Advance golden; cur_idx++; remaining--.
    - If remaining becomes 0, go to DONE, else SEND (with cur_idx+1).
  - Index wrap: cur_idx wraps 2^IDX_W-1 -> 0. On wrap, golden reloads a=0, b=1 instead of advancing.
  - Timeout: if the wait counter reaches TIMEOUT with no response, set timeout=1, err_cnt++, go to DONE (run aborted).
  - rsp_vld on the same cycle the counter hits TIMEOUT counts as a response, not a timeout.
  - The wait counter clears on entry to WAIT.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- rsp_vld outside WAIT: ignored (rsp_rdy=0). No state or counter change.
- Latency per request, with accelerator response after R cycles: SEND 1 cycle (if req_rdy already high) + WAIT R cycles.
- Reset mid-run: immediate abort to IDLE, all outputs 0. No done pulse. Any accelerator response after reset is ignored.

Test Plan:
- first_idx=0, num_req=5, model returns correct fib -> requests idx 0..4, responses 0,1,1,2,3; err_cnt=0, done pulses once, busy falls after done.
- first_idx=10, num_req=1, model returns 55 with req_rdy low for 3 cycles -> req_vld/req_idx=10 held stable 3 cycles; PRIME lasts 11 cycles; last_result=55, err_cnt=0.
- first_idx=47, num_req=2 -> expects 2971215073 then 512559680 (fib(48) mod 2^32); model returning 4807526976 truncated passes, model returning 0 for idx 48 gives err_cnt=1.
- TIMEOUT=8, model never asserts rsp_vld -> after 8 WAIT cycles timeout=1, err_cnt=1, done pulse; next start clears both.
- first_idx=254, num_req=3 -> req_idx 254,255,0; third expected value is 0 (golden reload on wrap).
- rst_n low during WAIT of a 4-request run -> all outputs 0 immediately, no done; a start after reset runs cleanly.
